// File: rtl/adaptive_threshold.sv
// Final adaptive-thresholding stage: streams pixel/mean pairs, writes a binary image and
// counts foreground pixels.
module adaptive_threshold #(
   parameter int unsigned WIDTH_BITS  = 8,
   parameter int unsigned HEIGHT_BITS = 8,
   parameter int unsigned WIDTH       = 2 ** WIDTH_BITS,
   parameter int unsigned HEIGHT      = 2 ** HEIGHT_BITS,
   parameter int          OFFSET      = 0,
   parameter int unsigned INVERT      = 0
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [2:0]                        global_state,
   output logic [WIDTH_BITS-1:0]             oReadCol,
   output logic [HEIGHT_BITS-1:0]            oReadRow,
   input  logic [7:0]                        iImageData,
   input  logic [7:0]                        iMeanData,
   output logic [WIDTH_BITS-1:0]             oResultCol,
   output logic [HEIGHT_BITS-1:0]            oResultRow,
   output logic [7:0]                        oResultData,
   output logic                              oResultWren,
   output logic [WIDTH_BITS+HEIGHT_BITS:0]   oForegroundCount,
   output logic                              finished
);

   localparam int unsigned PW   = WIDTH_BITS + HEIGHT_BITS;
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned NPIX = WIDTH * HEIGHT;
   localparam logic [PW-1:0]      LAST_POS = PW'(NPIX - 1);
   localparam logic signed [10:0] OFF11    = 11'(OFFSET);
   localparam logic               INV      = (INVERT != 0);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e                state_q, state_d;
   logic [PW-1:0]         pos_q, pos_d;
   logic                  s1_valid_q, s1_valid_d;
   logic [PW-1:0]         s1_addr_q, s1_addr_d;
   logic [WIDTH_BITS-1:0] res_col_q, res_col_d;
   logic [HEIGHT_BITS-1:0] res_row_q, res_row_d;
   logic [7:0]            res_data_q, res_data_d;
   logic                  res_wren_q, res_wren_d;
   logic [CW-1:0]         fg_count_q, fg_count_d;
   logic                  finished_q, finished_d;

   logic                  issue_c;
   logic signed [10:0]    diff_c;
   logic                  fg_c;

   // pixel + C - mean; 11 bits hold the full -510..510 range
   assign diff_c = $signed({3'b000, iImageData}) + OFF11 - $signed({3'b000, iMeanData});
   assign fg_c   = (diff_c > 11'sd0);
   assign issue_c = (state_q == RUN) && (global_state == 3'd2);

   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      s1_valid_d = issue_c;
      s1_addr_d  = s1_addr_q;
      res_col_d  = res_col_q;
      res_row_d  = res_row_q;
      res_data_d = res_data_q;
      res_wren_d = 1'b0;
      fg_count_d = fg_count_q;
      finished_d = finished_q;

      case (state_q)
         IDLE: begin
            if (global_state == 3'd2) state_d = RUN;
         end
         RUN: begin
            if (issue_c) begin
               s1_addr_d = pos_q;
               if (pos_q == LAST_POS) state_d = DRAIN;
               else                   pos_d   = pos_q + PW'(1);
            end
         end
         DRAIN: begin
            // the last beat has been registered once stage 1 is empty
            if (!s1_valid_q) begin
               state_d    = DONE;
               finished_d = 1'b1;
            end
         end
         DONE: begin
            finished_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (s1_valid_q) begin
         res_wren_d = 1'b1;
         res_col_d  = s1_addr_q[WIDTH_BITS-1:0];
         res_row_d  = s1_addr_q[PW-1:WIDTH_BITS];
         res_data_d = (fg_c ^ INV) ? 8'hFF : 8'h00;
         if (fg_c) fg_count_d = fg_count_q + CW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pos_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         res_col_q  <= '0;
         res_row_q  <= '0;
         res_data_q <= '0;
         res_wren_q <= 1'b0;
         fg_count_q <= '0;
         finished_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         s1_valid_q <= s1_valid_d;
         s1_addr_q  <= s1_addr_d;
         res_col_q  <= res_col_d;
         res_row_q  <= res_row_d;
         res_data_q <= res_data_d;
         res_wren_q <= res_wren_d;
         fg_count_q <= fg_count_d;
         finished_q <= finished_d;
      end
   end

   assign oReadCol         = pos_q[WIDTH_BITS-1:0];
   assign oReadRow         = pos_q[PW-1:WIDTH_BITS];
   assign oResultCol       = res_col_q;
   assign oResultRow       = res_row_q;
   assign oResultData      = res_data_q;
   assign oResultWren      = res_wren_q;
   assign oForegroundCount = fg_count_q;
   assign finished         = finished_q;

endmodule

// File: tb/tb_adaptive_threshold.sv
// Bench for adaptive_threshold: five 4x4 instances with different OFFSET/INVERT share stimulus;
// a scoreboard holds the expected write sequence of each instance.
module tb_adaptive_threshold;

   localparam int unsigned WB = 2;
   localparam int unsigned HB = 2;
   localparam int NP = 16;
   localparam int N  = 5;
   localparam int OFFS [N] = '{0, 0, 10, 11, -255};
   localparam int INVS [N] = '{0, 1, 0, 0, 0};

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] gs  = 3'd0;

   logic [WB-1:0] rcol [N];
   logic [HB-1:0] rrow [N];
   logic [WB-1:0] wcol [N];
   logic [HB-1:0] wrow [N];
   logic [7:0]    wdata [N];
   logic          wren [N];
   logic [4:0]    cnt [N];
   logic          fin [N];

   logic [7:0] img_mem  [N][NP];
   logic [7:0] mean_mem [N][NP];

   exp_t exp_q [N][$];
   int   exp_cnt [N];
   int   nchecks = 0;
   int   nerrors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      logic [7:0] img_rd, mean_rd;

      adaptive_threshold #(
         .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .WIDTH(4), .HEIGHT(4),
         .OFFSET(OFFS[g]), .INVERT(INVS[g])
      ) u_dut (
         .clock(clk), .reset(rst), .global_state(gs),
         .oReadCol(rcol[g]), .oReadRow(rrow[g]),
         .iImageData(img_rd), .iMeanData(mean_rd),
         .oResultCol(wcol[g]), .oResultRow(wrow[g]),
         .oResultData(wdata[g]), .oResultWren(wren[g]),
         .oForegroundCount(cnt[g]), .finished(fin[g])
      );

      // memories with one clock of read latency
      always @(posedge clk) begin
         img_rd  <= img_mem[g][{rrow[g], rcol[g]}];
         mean_rd <= mean_mem[g][{rrow[g], rcol[g]}];
      end
   end

   // scoreboard: every write must match the next expected pixel of that instance
   always @(negedge clk) begin : mon
      exp_t e;
      for (int g = 0; g < N; g++) begin
         if (wren[g]) begin
            nchecks++;
            if (exp_q[g].size() == 0) begin
               nerrors++;
               $display("FAIL extra_write inst%0d: got addr %0d data %h, required no write",
                        g, {wrow[g], wcol[g]}, wdata[g]);
            end else begin
               e = exp_q[g].pop_front();
               if ({wrow[g], wcol[g]} !== e.addr || wdata[g] !== e.data) begin
                  nerrors++;
                  $display("FAIL write inst%0d: got addr %0d data %h, required addr %0d data %h",
                           g, {wrow[g], wcol[g]}, wdata[g], e.addr, e.data);
               end
            end
         end
         if (fin[g] && exp_q[g].size() != 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL early_finish inst%0d: got finished with %0d writes pending, required 0",
                     g, exp_q[g].size());
         end
      end
   end

   // fill memories (mode 0: directed values, mode 1: random with many near-ties) and push expectations
   task automatic load_push(input int mode);
      int m, img, fg;
      exp_t e;
      for (int g = 0; g < N; g++) begin
         exp_cnt[g] = 0;
         for (int a = 0; a < NP; a++) begin
            if (mode == 0) begin
               img = (g < 2) ? 100 : (g < 4) ? 90 : 255;
               m   = (g < 2) ? 90  : (g < 4) ? 100 : 0;
            end else begin
               img = int'($urandom_range(0, 255));
               if ($urandom_range(0, 1) == 1) m = img + OFFS[g] + int'($urandom_range(0, 2)) - 1;
               else                           m = int'($urandom_range(0, 255));
               if (m < 0)   m = 0;
               if (m > 255) m = 255;
            end
            img_mem[g][a]  = 8'(img);
            mean_mem[g][a] = 8'(m);
            fg = (img + OFFS[g] - m > 0) ? 1 : 0;
            exp_cnt[g] += fg;
            e.addr = 4'(a);
            e.data = ((fg ^ INVS[g]) != 0) ? 8'hFF : 8'h00;
            exp_q[g].push_back(e);
         end
      end
   endtask

   task automatic do_reset();
      gs  = 3'd0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int g = 0; g < N; g++) begin
         exp_q[g].delete();
         exp_cnt[g] = 0;
      end
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int g = 0; g < N; g++) begin
         nchecks++;
         if ({rcol[g], rrow[g], wcol[g], wrow[g], wdata[g], wren[g], cnt[g], fin[g]} !== '0) begin
            nerrors++;
            $display("FAIL reset_state inst%0d: got %h, required 0", g,
                     {rcol[g], rrow[g], wcol[g], wrow[g], wdata[g], wren[g], cnt[g], fin[g]});
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_frame(input int mode, input string name);
      int cyc = -1, fin_at = -1;
      load_push(mode);
      gs = 3'd2;
      while (fin_at < 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (fin[0]) fin_at = cyc;
      end
      nchecks++;
      if (fin_at != 18) begin
         nerrors++;
         $display("FAIL %s_finish_cycle: got %0d, required 18", name, fin_at);
      end
      for (int g = 0; g < N; g++) begin
         nchecks++;
         if (cnt[g] !== 5'(exp_cnt[g]) || exp_q[g].size() != 0 || fin[g] !== 1'b1) begin
            nerrors++;
            $display("FAIL %s_end inst%0d: got count %0d pending %0d fin %b, required count %0d pending 0 fin 1",
                     name, g, cnt[g], exp_q[g].size(), fin[g], exp_cnt[g]);
         end
      end
   endtask

   task automatic test_pause();
      int cyc = -1, fin_at = -1, pause_wr = 0;
      do_reset();
      load_push(0);
      gs = 3'd2;
      while (fin_at < 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (fin[0]) fin_at = cyc;
         if (cyc >= 6 && cyc <= 8 && wren[0]) pause_wr++;
         if (cyc == 7) begin
            nchecks++;
            if ({rrow[0], rcol[0]} !== 4'd5) begin
               nerrors++;
               $display("FAIL pause_hold_addr: got %0d, required 5", {rrow[0], rcol[0]});
            end
         end
         if (cyc == 5) gs = 3'd0;
         if (cyc == 8) gs = 3'd2;
      end
      nchecks++;
      if (pause_wr > 1) begin
         nerrors++;
         $display("FAIL pause_writes: got %0d, required at most 1", pause_wr);
      end
      nchecks++;
      if (fin_at != 21 || cnt[0] !== 5'd16 || exp_q[0].size() != 0) begin
         nerrors++;
         $display("FAIL pause_end: got fin_cycle %0d count %0d pending %0d, required 21 16 0",
                  fin_at, cnt[0], exp_q[0].size());
      end
   endtask

   task automatic test_reset_midframe();
      int cyc = -1;
      do_reset();
      load_push(0);
      gs = 3'd2;
      while (cyc < 7) begin
         @(negedge clk);
         cyc++;
      end
      #2 rst = 1'b1;
      #1;
      for (int g = 0; g < N; g++) begin
         nchecks++;
         if ({rcol[g], rrow[g], wcol[g], wrow[g], wdata[g], wren[g], cnt[g], fin[g]} !== '0) begin
            nerrors++;
            $display("FAIL async_reset inst%0d: got %h, required 0", g,
                     {rcol[g], rrow[g], wcol[g], wrow[g], wdata[g], wren[g], cnt[g], fin[g]});
         end
      end
      do_reset();
      test_frame(0, "restart");
   endtask

   task automatic test_after_done();
      int wr = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         gs = (i % 2 == 0) ? 3'd0 : 3'd2;
         for (int g = 0; g < N; g++) if (wren[g]) wr++;
      end
      for (int g = 0; g < N; g++) begin
         nchecks++;
         if (wr != 0 || fin[g] !== 1'b1 || cnt[g] !== 5'(exp_cnt[g])) begin
            nerrors++;
            $display("FAIL after_done inst%0d: got writes %0d fin %b count %0d, required 0 1 %0d",
                     g, wr, fin[g], cnt[g], exp_cnt[g]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame(0, "directed");
      do_reset();
      test_frame(1, "random_a");
      do_reset();
      test_frame(1, "random_b");
      test_pause();
      test_reset_midframe();
      test_after_done();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
